// File: rtl/prog_load_ctrl_pkg.sv
// Shared constants for the boot loader: global mode encoding, default ack byte and
// the loader FSM state type.
package prog_load_ctrl_pkg;

  // Global core mode, also consumed by fetch and the core top.
  typedef enum logic [2:0] {
    STALL = 3'd0,
    LOAD  = 3'd1,
    EXEC  = 3'd2
  } mode_t;

  localparam logic [7:0] AckByteDefault = 8'hAA;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StAck,
    StRun,
    StErr
  } state_e;

  // Mode presented to the rest of the core for each loader state.
  function automatic mode_t state_mode(input state_e s);
    unique case (s)
      StHdr, StData, StAck: return LOAD;
      StRun:                return EXEC;
      default:              return STALL;
    endcase
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a big-endian byte stream into 32-bit words. The first byte of a word lands in
// [31:24]. word_valid pulses combinationally in the cycle the fourth byte is presented,
// with word already holding the full packed value.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // Next byte position and partial-word shift register; clr realigns to byte 0.
  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    word       = {shift_q, in_data};
    word_valid = in_valid && !clr && (cnt_q == 2'd3);
    if (clr) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (in_valid) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], in_data};
    end
  end

  // Byte counter and shift register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// Program boot sequencer: receives a word-count header and instruction words over the UART
// byte stream, writes them into instruction memory, acks the host and releases the core.
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  ACK_BYTE    = AckByteDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mode,
  output logic              done,
  output logic              err
);

  localparam int unsigned IdxW     = ADDR_W + 1;
  // Header values above this do not fit in instruction memory.
  localparam logic [32:0] MaxWords = 33'(1) << ADDR_W;
  // Idle count from which one more silent cycle reaches TIMEOUT_CYC-1.
  localparam logic [31:0] ToLast   = 32'(TIMEOUT_CYC - 2);

  state_e            state_q, state_d;
  logic [31:0]       hdr_q, hdr_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       to_q, to_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic        receiving;
  logic        byte_in;
  logic        start_ok;
  logic [31:0] pk_word;
  logic        pk_valid;
  logic        hdr_zero;
  logic        hdr_big;
  logic [31:0] idx_ext;
  logic        data_wr;
  logic        last_wr_done;
  logic        timeout;

  assign receiving    = (state_q == StHdr) || (state_q == StData);
  assign byte_in      = rx_valid && receiving;
  assign start_ok     = start && ((state_q == StIdle) || (state_q == StErr));
  assign hdr_zero     = (pk_word == 32'd0);
  assign hdr_big      = ({1'b0, pk_word} > MaxWords);
  assign idx_ext      = 32'(idx_q);
  // Words past N are absorbed by the packer but never written.
  assign data_wr      = (state_q == StData) && pk_valid && (idx_ext < hdr_q);
  // The final write is in flight when the index has already reached N.
  assign last_wr_done = (state_q == StData) && mem_we_q && (idx_ext == hdr_q);
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timeout      = receiving && !rx_valid && (to_q == ToLast);

  byte_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start_ok),
    .in_valid   (byte_in),
    .in_data    (rx_data),
    .word       (pk_word),
    .word_valid (pk_valid)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StErr: begin
        if (start) state_d = StHdr;
      end
      StHdr: begin
        if (pk_valid) begin
          if (hdr_big)       state_d = StErr;
          else if (hdr_zero) state_d = StAck;
          else               state_d = StData;
        end else if (timeout) begin
          state_d = StErr;
        end
      end
      StData: begin
        if (last_wr_done) state_d = StAck;
        else if (timeout) state_d = StErr;
      end
      StAck: begin
        if (tx_ready) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, decoded from the current state.
  always_comb begin
    mode      = state_mode(state_q);
    tx_valid  = (state_q == StAck);
    tx_data   = (state_q == StAck) ? ACK_BYTE : 8'd0;
    done      = (state_q == StRun);
    err       = (state_q == StErr);
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end

  // Datapath next-state: header capture, word index, idle timer, write port.
  always_comb begin
    hdr_d       = hdr_q;
    idx_d       = idx_q;
    to_d        = 32'd0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == StHdr && pk_valid) hdr_d = pk_word;
    if (start_ok) begin
      idx_d = '0;
    end else if (data_wr) begin
      idx_d = idx_q + IdxW'(1);
    end
    if (!start_ok && !byte_in && receiving) to_d = to_q + 32'd1;
    if (data_wr) begin
      mem_addr_d  = idx_q[ADDR_W-1:0];
      mem_wdata_d = pk_word;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q       <= 32'd0;
      idx_q       <= '0;
      to_q        <= 32'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      hdr_q       <= hdr_d;
      idx_q       <= idx_d;
      to_q        <= to_d;
      mem_we_q    <= data_wr;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl: table of load scenarios plus hand-written
// sequences for timeout, ack back-pressure and mid-load reset. Memory writes are checked
// by a scoreboard fed when data words are driven.
module tb_prog_load_ctrl;
  import prog_load_ctrl_pkg::*;

  localparam int unsigned AW = 4;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_ready;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [2:0]    mode;
  logic          done;
  logic          err;

  always #5 clk = ~clk;

  prog_load_ctrl #(
    .ADDR_W      (AW),
    .TIMEOUT_CYC (TO),
    .ACK_BYTE    (8'hAA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mode      (mode),
    .done      (done),
    .err       (err)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [31:0] n;
    logic [31:0] seed;
    bit          exp_err;
    bit          keep;    // continue from the previous state instead of resetting
    string       tag;
  } vec_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] words_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write-port monitor: every pulse must match the next expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_writes++;
      check("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("wr_data", mem_wdata, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit push, input logic [AW-1:0] addr);
    if (push) exp_q.push_back('{addr: addr, data: w});
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_tx(input string tag);
    for (int i = 0; i < 20 && tx_valid !== 1'b1; i++) tick();
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd1);
  endtask

  // Start, send header and (unless an error is expected) all words, then wait for ACK.
  task automatic load_body(input logic [31:0] n, input bit exp_err, input string tag);
    n_writes = 0;
    pulse_start();
    check({tag, "_start_err"}, 32'(err), 32'd0);
    check({tag, "_start_mode"}, 32'(mode), 32'(LOAD));
    send_word(n, 1'b0, '0);
    if (exp_err) begin
      check({tag, "_hdr_err"}, 32'(err), 32'd1);
      check({tag, "_hdr_err_mode"}, 32'(mode), 32'(STALL));
      repeat (3) tick();
      check({tag, "_hdr_err_writes"}, 32'(n_writes), 32'd0);
    end else begin
      for (int i = 0; i < int'(n); i++) send_word(words_q[i], 1'b1, AW'(i));
      wait_tx(tag);
    end
  endtask

  task automatic ack_finish(input logic [31:0] n, input string tag);
    check({tag, "_ack_data"}, 32'(tx_data), 32'hAA);
    check({tag, "_ack_mode"}, 32'(mode), 32'(LOAD));
    check({tag, "_ack_done"}, 32'(done), 32'd0);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check({tag, "_run_mode"}, 32'(mode), 32'(EXEC));
    check({tag, "_run_done"}, 32'(done), 32'd1);
    check({tag, "_run_txv"}, 32'(tx_valid), 32'd0);
    check({tag, "_writes"}, 32'(n_writes), n);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_words(input logic [31:0] n, input logic [31:0] seed);
    words_q.delete();
    for (int i = 0; i < int'(n); i++) words_q.push_back(seed ^ (32'(i) * 32'h9E3779B9));
  endtask

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs.push_back('{n: 32'd0,     seed: 32'h0,        exp_err: 1'b0, keep: 1'b0, tag: "n0"});
    vecs.push_back('{n: 32'd3,     seed: 32'h0BADF00D, exp_err: 1'b0, keep: 1'b0, tag: "n3"});
    vecs.push_back('{n: 32'd16,    seed: 32'hC0FFEE00, exp_err: 1'b0, keep: 1'b0, tag: "full"});
    vecs.push_back('{n: 32'd17,    seed: 32'h0,        exp_err: 1'b1, keep: 1'b0, tag: "n17"});
    vecs.push_back('{n: 32'd1,     seed: 32'h5A5A1234, exp_err: 1'b0, keep: 1'b1, tag: "after_err"});
    vecs.push_back('{n: 32'h10000, seed: 32'h0,        exp_err: 1'b1, keep: 1'b0, tag: "huge"});

    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    tick();
    tick();
    check("rst_mode", 32'(mode), 32'(STALL));
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_txv", 32'(tx_valid), 32'd0);
    check("rst_txd", 32'(tx_data), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    // Bytes while idle are ignored.
    send_byte(8'h12);
    tick();
    check("idle_rx_writes", 32'(mem_we), 32'd0);
    check("idle_rx_mode", 32'(mode), 32'(STALL));

    // Two-word load with fixed words.
    words_q.delete();
    words_q.push_back(32'h11223344);
    words_q.push_back(32'hDEADBEEF);
    load_body(32'd2, 1'b0, "basic");
    ack_finish(32'd2, "basic");
    pulse_start();
    check("run_start_ignored", 32'(mode), 32'(EXEC));

    // Table-driven scenarios.
    foreach (vecs[k]) begin
      if (!vecs[k].keep) do_reset();
      if (!vecs[k].exp_err) fill_words(vecs[k].n, vecs[k].seed);
      load_body(vecs[k].n, vecs[k].exp_err, vecs[k].tag);
      if (!vecs[k].exp_err) ack_finish(vecs[k].n, vecs[k].tag);
    end

    // Timeout: two bytes of a word, then silence.
    do_reset();
    n_writes = 0;
    pulse_start();
    send_word(32'd1, 1'b0, '0);
    send_byte(8'hAB);
    send_byte(8'hCD);
    repeat (TO - 2) tick();
    check("to_before_err", 32'(err), 32'd0);
    tick();
    check("to_err", 32'(err), 32'd1);
    check("to_err_mode", 32'(mode), 32'(STALL));
    // Byte on the expiry cycle keeps the load alive.
    n_writes = 0;
    pulse_start();
    check("to_restart_err", 32'(err), 32'd0);
    send_word(32'd1, 1'b0, '0);
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (TO - 2) tick();
    exp_q.push_back('{addr: '0, data: 32'h01020304});
    send_byte(8'h03);
    check("to_expiry_byte_err", 32'(err), 32'd0);
    send_byte(8'h04);
    wait_tx("to_late");
    ack_finish(32'd1, "to_late");

    // ACK held off by tx_ready.
    do_reset();
    words_q.delete();
    words_q.push_back(32'hCAFEF00D);
    load_body(32'd1, 1'b0, "hold");
    for (int i = 0; i < 10; i++) begin
      check("hold_txv", 32'(tx_valid), 32'd1);
      check("hold_txd", 32'(tx_data), 32'hAA);
      check("hold_mode", 32'(mode), 32'(LOAD));
      check("hold_done", 32'(done), 32'd0);
      tick();
    end
    ack_finish(32'd1, "hold");

    // Reset in the middle of a data word.
    do_reset();
    n_writes = 0;
    pulse_start();
    send_word(32'd2, 1'b0, '0);
    send_word(32'h0F0E0D0C, 1'b1, AW'(0));
    send_byte(8'h77);
    send_byte(8'h66);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_mode", 32'(mode), 32'(STALL));
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_txv", 32'(tx_valid), 32'd0);
    check("mid_rst_flags", 32'({done, err}), 32'd0);
    send_byte(8'h55);
    send_byte(8'h44);
    tick();
    check("mid_rst_no_write", 32'(n_writes), 32'd1);
    fill_words(32'd2, 32'h76543210);
    load_body(32'd2, 1'b0, "reload");
    ack_finish(32'd2, "reload");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
